// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write arbiter.
// Latency: n/a (types/constants only).
// Backpressure: n/a.
package fifo_arb_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 16;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request scanning from ptr upward, modulo N.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is asserted.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [PW:0]   scan_pos;
    logic [PW-1:0] cand;
    logic          found;

    // Walk ptr, ptr+1, ... (mod N) and stop at the first requester seen.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        scan_pos = '0;
        cand     = '0;
        for (int j = 0; j < N; j++) begin
            scan_pos = {1'b0, ptr} + (PW+1)'(j);
            if (scan_pos >= (PW+1)'(N)) begin
                scan_pos = scan_pos - (PW+1)'(N);
            end
            cand = scan_pos[PW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin N:1 write arbiter in front of a DEPTH-entry FIFO; optional level port via FIFO_ARB_LEVEL_EN.
// Latency: accepted word appears on fifo_wr/fifo_din one cycle after the accepting edge.
// Backpressure: gnt withheld while internal occupancy (incl. in-flight word) equals DEPTH.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = calc_cw(DEPTH),
    localparam int PW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]    gnt,
    input  logic            fifo_rd,
    output logic            fifo_wr,
    output logic [DW-1:0]   fifo_din
`ifdef FIFO_ARB_LEVEL_EN
    ,
    output logic [CW-1:0]   level
`endif
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_wr_q, fifo_wr_d;
    logic [DW-1:0] fifo_din_q, fifo_din_d;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          eligible;
    logic          accept;
    logic [CW-1:0] stored;
    logic          rd_eff;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Grant gating: only the registered count decides eligibility, so fifo_rd
    // never reaches gnt combinationally; gnt is also forced low during reset.
    always_comb begin
        eligible = (count_q < CW'(DEPTH));
        gnt      = (eligible && rst) ? pick_gnt : '0;
        accept   = |gnt;
        // The in-flight word is counted but not yet stored in the FIFO.
        stored   = count_q - CW'(fifo_wr_q);
        rd_eff   = fifo_rd && (stored != '0);
    end

    // Next-state for pointer, occupancy and the write-port registers.
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        fifo_wr_d  = 1'b0;
        fifo_din_d = fifo_din_q;
        if (accept) begin
            fifo_wr_d  = 1'b1;
            fifo_din_d = data[int'(pick_idx)*DW +: DW];
            ptr_d      = (int'(pick_idx) == N-1) ? '0 : pick_idx + PW'(1);
        end
        case ({accept, rd_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            count_q    <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
        end
    end

    assign fifo_wr  = fifo_wr_q;
    assign fifo_din = fifo_din_q;
`ifdef FIFO_ARB_LEVEL_EN
    assign level    = count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, DW=8, DEPTH=16) with a behavioural FIFO model.
// Latency: inputs driven 1ns after rising edge, outputs sampled 1ns after that.
// Backpressure: FIFO model mirrors the downstream 16-deep buffer fed by fifo_wr/fifo_din.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  gnt;
    logic        fifo_rd = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
`ifdef FIFO_ARB_LEVEL_EN
    logic [4:0]  level;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(4), .DW(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .fifo_rd  (fifo_rd),
        .fifo_wr  (fifo_wr),
        .fifo_din (fifo_din)
`ifdef FIFO_ARB_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    // Downstream FIFO model: read pops first (only if non-empty), then write pushes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_dout <= '0;
        end else begin
            if (fifo_rd && mq.size() != 0) m_dout <= mq.pop_front();
            if (fifo_wr) mq.push_back(fifo_din);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req = '0;
        fifo_rd = 1'b0;
        data = '0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req = 4'b1111;
        data = 32'h33221100;
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt_held: got %b want 0000", gnt); end
        total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL rst_wr_init: got %b want 0", fifo_wr); end
        total++; if (fifo_din !== 8'h00) begin bad++; $display("FAIL rst_din_init: got %h want 00", fifo_din); end
        rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
        step();
        total++; if (fifo_wr !== 1'b1 || fifo_din !== 8'h00) begin bad++; $display("FAIL rst_first_xfer: got wr=%b din=%h want wr=1 din=00", fifo_wr, fifo_din); end
        // ptr is now 1; lane 1 word is 0x11
        #1;
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_second_gnt: got %b want 0010", gnt); end
        step();
        total++; if (fifo_din !== 8'h11) begin bad++; $display("FAIL rst_second_din: got %h want 11", fifo_din); end
        // Mid-stream asynchronous reset with fifo_wr high
        #2;
        rst = 1'b0;
        #1;
        total++; if (fifo_wr !== 1'b0) begin bad++; $display("FAIL rst_async_wr: got %b want 0", fifo_wr); end
        total++; if (fifo_din !== 8'h00) begin bad++; $display("FAIL rst_async_din: got %h want 00", fifo_din); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_async_gnt: got %b want 0000", gnt); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd0) begin bad++; $display("FAIL rst_async_level: got %0d want 0", level); end
`endif
        rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_release_gnt: got %b want 0001", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_fill_all;
        logic [3:0] exp_g;
        do_reset();
        data = 32'hA3A2A1A0;
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL fill_gnt_%0d: got %b want %b", k, gnt, exp_g); end
            step();
            total++; if (fifo_wr !== 1'b1 || fifo_din !== (8'hA0 + 8'(k % 4))) begin
                bad++; $display("FAIL fill_xfer_%0d: got wr=%b din=%h want wr=1 din=%h", k, fifo_wr, fifo_din, 8'hA0 + 8'(k % 4));
            end
        end
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL full_gnt_0: got %b want 0000", gnt); end
        step();
        total++; if (gnt !== 4'b0000 || fifo_wr !== 1'b0) begin bad++; $display("FAIL full_hold: got gnt=%b wr=%b want 0000/0", gnt, fifo_wr); end
        step();
        total++; if (mq.size() != 16) begin bad++; $display("FAIL full_model_size: got %0d want 16", mq.size()); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level: got %0d want 16", level); end
`endif
    endtask

    task automatic test_full_read;
        // Continues from a full FIFO with req=1111, ptr=0
        fifo_rd = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fullrd_no_comb: got %b want 0000", gnt); end
        step();
        fifo_rd = 1'b0;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fullrd_regrant: got %b want 0001", gnt); end
        total++; if (m_dout !== 8'hA0) begin bad++; $display("FAIL fullrd_dout: got %h want a0", m_dout); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd15) begin bad++; $display("FAIL fullrd_level15: got %0d want 15", level); end
`endif
        step();
        total++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hA0) begin bad++; $display("FAIL fullrd_xfer: got wr=%b din=%h want 1/a0", fifo_wr, fifo_din); end
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fullrd_refull: got %b want 0000", gnt); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd16) begin bad++; $display("FAIL fullrd_level16: got %0d want 16", level); end
`endif
        req = '0;
        step();
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            data[2*8 +: 8] = 8'(k);
            #1;
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt_%0d: got %b want 0100", k, gnt); end
            step();
            total++; if (fifo_wr !== 1'b1 || fifo_din !== 8'(k)) begin bad++; $display("FAIL single_din_%0d: got wr=%b din=%h want 1/%h", k, fifo_wr, fifo_din, 8'(k)); end
        end
        req = '0;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_idle_gnt: got %b want 0000", gnt); end
        step();
        total++; if (fifo_wr !== 1'b0 || fifo_din !== 8'h05) begin bad++; $display("FAIL single_idle_wr: got wr=%b din=%h want 0/05", fifo_wr, fifo_din); end
    endtask

    task automatic test_rd_same_edge;
        int acc;
        do_reset();
        data[7:0] = 8'h5A;
        req = 4'b0001;
        fifo_rd = 1'b1;
        step();                 // edge t: accept, read of empty FIFO ignored
        req = '0;
        total++; if (fifo_wr !== 1'b1) begin bad++; $display("FAIL rdse_inflight: got %b want 1", fifo_wr); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd1) begin bad++; $display("FAIL rdse_level_t: got %0d want 1", level); end
`endif
        step();                 // edge t+1: in-flight word not readable
        fifo_rd = 1'b0;
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd1) begin bad++; $display("FAIL rdse_level_t1: got %0d want 1", level); end
`endif
        total++; if (mq.size() != 1) begin bad++; $display("FAIL rdse_model_size: got %0d want 1", mq.size()); end
        fifo_rd = 1'b1;
        step();                 // edge t+2: effective read
        fifo_rd = 1'b0;
        total++; if (m_dout !== 8'h5A) begin bad++; $display("FAIL rdse_dout: got %h want 5a", m_dout); end
`ifdef FIFO_ARB_LEVEL_EN
        total++; if (level !== 5'd0) begin bad++; $display("FAIL rdse_level_t2: got %0d want 0", level); end
`endif
        // Occupancy must be back to zero: exactly 16 accepts fit.
        acc = 0;
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (gnt != 4'b0000) acc++;
            step();
        end
        req = '0;
        total++; if (acc != 16) begin bad++; $display("FAIL rdse_refill: got %0d accepts want 16", acc); end
    endtask

    task automatic test_rr_skip;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0010;
        exp_seq[3] = 4'b1000;
        do_reset();
        data = 32'hD3D2D1D0;
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (gnt !== exp_seq[k]) begin bad++; $display("FAIL rr_gnt_%0d: got %b want %b", k, gnt, exp_seq[k]); end
            step();
        end
        req = 4'b1011;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rr_late_req0: got %b want 0001", gnt); end
        step();
        total++; if (fifo_din !== 8'hD0) begin bad++; $display("FAIL rr_late_din: got %h want d0", fifo_din); end
        #1;
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rr_after0: got %b want 0010", gnt); end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_all();
        test_full_read();
        test_single();
        test_rd_same_edge();
        test_rr_skip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
